if_fetch_unit: RTL and testbench

//  IF stage: owns the PC, drives a req/ready instruction-memory handshake, and

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 tb/tb_if_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the req/ready instruction-memory handshake.
// It presents {PC+4, instruction, fetch_valid} to IF/ID and drops wrong-path fetches after a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PC_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_plus4,
    output logic [31:0] instruction,
    output logic        fetch_valid,
    output logic        IF_Flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] redirect_target;

    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with other flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            pc_plus4_q <= 32'h0;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;

        if (redirect) begin
            // An in-flight request cannot be aborted; it is completed and dropped from DISCARD.
            pc_d    = redirect_target;
            valid_d = 1'b0;
            if (imem_req && !imem_ready) begin
                state_d = S_DISCARD;
                addr_d  = imem_addr;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    addr_d = pc_q;
                    if (imem_ready) begin
                        instr_d    = imem_rdata;
                        pc_plus4_d = pc_q + 32'd4;
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        state_d    = PC_Write ? S_REQ : S_HOLD;
                    end else begin
                        // IF/ID consumes the presented word whenever PC_Write is high.
                        valid_d = valid_q & ~PC_Write;
                    end
                end
                S_HOLD: begin
                    if (PC_Write) state_d = S_REQ;
                end
                S_DISCARD: begin
                    if (imem_ready) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        unique case (state_q)
            S_REQ:     imem_req = 1'b1;
            S_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
            end
            default:   imem_req = 1'b0;
        endcase
    end

    assign IF_Flush    = redirect;
    assign PC_plus4    = pc_plus4_q;
    assign instruction = instr_q;
    assign fetch_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: the memory returns addr ^ 0xA5A5_0000.
// The bench controls when the memory is ready.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        PC_Write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PC_plus4;
    logic [31:0] instruction;
    logic        fetch_valid;
    logic        IF_Flush;
    logic        mem_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_ready = mem_rdy & imem_req;
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .PC_Write      (PC_Write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .PC_plus4      (PC_plus4),
        .instruction   (instruction),
        .fetch_valid   (fetch_valid),
        .IF_Flush      (IF_Flush)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        PC_Write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        mem_rdy       = 1'b1;

        // Reset state
        #12;
        check("rst_req",   imem_req,    32'h0);
        check("rst_pc4",   PC_plus4,    32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_valid", fetch_valid, 32'h0);
        reset_n = 1'b1;

        // Zero-wait back-to-back fetch from RESET_PC
        tick();
        check("t1_req0",  imem_req,  32'h1);
        check("t1_addr0", imem_addr, 32'h0000_0100);
        tick();
        check("t1_addr1",  imem_addr,   32'h0000_0104);
        check("t1_pc4_1",  PC_plus4,    32'h0000_0104);
        check("t1_instr1", instruction, 32'hA5A5_0100);
        check("t1_valid1", fetch_valid, 32'h1);
        tick();
        check("t1_addr2", imem_addr, 32'h0000_0108);
        check("t1_pc4_2", PC_plus4,  32'h0000_0108);

        // Jump on the same edge as a completion: the data is dropped
        jump        = 1'b1;
        jump_target = 32'h0000_0200;
        #1;
        check("t2_flush", IF_Flush, 32'h1);
        tick();
        jump    = 1'b0;
        mem_rdy = 1'b0;
        check("t2_addr_a",  imem_addr,   32'h0000_0200);
        check("t2_valid_a", fetch_valid, 32'h0);
        check("t2_pc4_a",   PC_plus4,    32'h0000_0108);
        check("t2_instr_a", instruction, 32'hA5A5_0104);
        // Three-cycle-late memory at 0x200
        tick();
        check("t2_addr_b",  imem_addr,   32'h0000_0200);
        check("t2_valid_b", fetch_valid, 32'h0);
        tick();
        check("t2_addr_c",  imem_addr,   32'h0000_0200);
        check("t2_req_c",   imem_req,    32'h1);
        mem_rdy = 1'b1;
        tick();
        check("t2_instr", instruction, 32'hA5A5_0200);
        check("t2_pc4",   PC_plus4,    32'h0000_0204);
        check("t2_valid", fetch_valid, 32'h1);
        check("t2_next",  imem_addr,   32'h0000_0204);

        // PC_Write stall: capture 0x204, then hold
        PC_Write = 1'b0;
        tick();
        check("t3_req_a",   imem_req,    32'h0);
        check("t3_instr_a", instruction, 32'hA5A5_0204);
        check("t3_pc4_a",   PC_plus4,    32'h0000_0208);
        check("t3_valid_a", fetch_valid, 32'h1);
        tick();
        check("t3_req_b",   imem_req,    32'h0);
        check("t3_instr_b", instruction, 32'hA5A5_0204);
        check("t3_pc4_b",   PC_plus4,    32'h0000_0208);
        PC_Write = 1'b1;
        tick();
        check("t3_resume_req",  imem_req,  32'h1);
        check("t3_resume_addr", imem_addr, 32'h0000_0208);

        // Branch while a 2-cycle-wait fetch to 0x208 is pending
        mem_rdy = 1'b0;
        tick();
        check("t4_pend_addr", imem_addr, 32'h0000_0208);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0400;
        #1;
        check("t4_flush", IF_Flush, 32'h1);
        tick();
        branch_taken = 1'b0;
        check("t4_disc_addr",  imem_addr,   32'h0000_0208);
        check("t4_disc_req",   imem_req,    32'h1);
        check("t4_disc_valid", fetch_valid, 32'h0);
        mem_rdy = 1'b1;
        tick();
        check("t4_drop_instr", instruction, 32'hA5A5_0204);
        check("t4_drop_pc4",   PC_plus4,    32'h0000_0208);
        check("t4_drop_valid", fetch_valid, 32'h0);
        check("t4_new_addr",   imem_addr,   32'h0000_0400);
        tick();
        check("t4_instr", instruction, 32'hA5A5_0400);
        check("t4_pc4",   PC_plus4,    32'h0000_0404);

        // Branch and jump together: the branch target wins
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        jump          = 1'b1;
        jump_target   = 32'h0000_0080;
        tick();
        branch_taken = 1'b0;
        jump         = 1'b0;
        check("t5_addr",  imem_addr,   32'h0000_0040);
        check("t5_valid", fetch_valid, 32'h0);
        tick();
        check("t5_pc4",   PC_plus4,    32'h0000_0044);
        check("t5_instr", instruction, 32'hA5A5_0040);

        // PC wrap at the top of the address space
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        check("t6_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_wrap_pc4",   PC_plus4,    32'h0000_0000);
        check("t6_wrap_instr", instruction, 32'h5A5A_FFFC);
        check("t6_wrap_next",  imem_addr,   32'h0000_0000);

        // Asynchronous reset in the middle of a pending request
        mem_rdy = 1'b0;
        tick();
        check("t6_pending", imem_req, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_req",   imem_req,    32'h0);
        check("t6_rst_pc4",   PC_plus4,    32'h0);
        check("t6_rst_instr", instruction, 32'h0);
        check("t6_rst_valid", fetch_valid, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_rdy = 1'b1;
        tick();
        check("t6_restart_req",  imem_req,  32'h1);
        check("t6_restart_addr", imem_addr, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
